multiword_add_sequencer: RTL and testbench
==========================================

Name: multiword_add_sequencer

Overview:
- Word-serial wide-operand adder control stage sitting directly upstream and downstream of the team's 32-bit ripple adder.
- Streams operand word pairs (LSW first) into the adder's A/B/Cin and captures S/Cout into a one-entry output register with valid/ready backpressure.
- Holds the inter-word carry in a register so N x 32-bit additions complete over N accepted words.

Parameters:
- NWORDS, 4, maximum words per operation (operand width = 32*NWORDS); NWORDS >= 1.
- CNT_W, $clog2(NWORDS)+1, word counter width.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin operation; honoured only in IDLE.
- Cin  input  1  initial carry, sampled with start.
- in_valid  input  1  operand word pair valid.
- in_ready  output  1  sequencer accepts word this cycle.
- in_A  input  32  operand A word.
- in_B  input  32  operand B word.
- in_last  input  1  marks final word of operation.
- add_A  output  32  to adder A.
- add_B  output  32  to adder B.
- add_Cin  output  1  to adder Cin (carry register).
- add_S  input  32  from adder S.
- add_Cout  input  1  from adder Cout.
- out_valid  output  1  result word valid.
- out_ready  input  1  downstream accepts result word.
- out_S  output  32  result word.
- out_last  output  1  result word is final word.
- out_Cout  output  1  carry out of this word; the final carry when out_last=1.
- word_cnt  output  CNT_W  words accepted in current operation.
- done  output  1  one-cycle pulse when the final word leaves the output register.

Behaviour:
- Reset (async, immediate): state=IDLE; carry_q=0; word_cnt=0; out_valid=0; out_S=0; out_last=0; out_Cout=0; done=0.
- States:
  - IDLE: in_ready=0. start=1 loads carry_q<=Cin, word_cnt<=0, then goes to RUN.
  - RUN: accepts words.
  - DRAIN: final word is captured; wait for its output handshake.
- Adder drive (combinational): add_A=in_A, add_B=in_B, add_Cin=carry_q. Adder latency is zero; the result registers on the accept edge.
- in_ready = (state==RUN) && (!out_valid || out_ready).
- Accept = in_valid && in_ready. On accept:
  - out_S<=add_S; out_Cout<=add_Cout; out_valid<=1; carry_q<=add_Cout; word_cnt<=word_cnt+1.
  - out_last<=in_last || (word_cnt==NWORDS-1).
  - If out_last is set, state goes to DRAIN.
- Forced last: reaching NWORDS accepted words ends the operation even if in_last=0.
- Output handshake: out_valid && out_ready clears out_valid unless a new accept occurs in the same cycle. With a simultaneous accept, the register reloads and out_valid stays 1, giving 1 word/cycle throughput.
- DRAIN: in_ready=0. When the last word's output handshake completes, done=1 for one cycle and state goes to IDLE.
- start outside IDLE is ignored.
- start in the same cycle as the DRAIN->IDLE transition is ignored; start must be reasserted in IDLE.
- word_cnt holds its final value in IDLE until the next start.
- in_valid in IDLE or DRAIN is not accepted, and no state changes.
- out_valid must not drop without a handshake; out_S/out_last/out_Cout stay stable while out_valid && !out_ready.
- Mid-operation reset aborts: partial results are discarded, all outputs return to reset values.

Optional Feature:
- Macro: ADDSEQ_SUBTRACT_EN.
- Defined:
  - Adds input port sub (1 bit), sampled with start into sub_q.
  - When sub_q=1: add_B=~in_B, and carry_q loads 1 at start (Cin ignored), computing A-B in two's complement.
  - Final out_Cout=1 means no borrow.
  - When sub_q=0: behaviour is identical to the undefined case.
- Undefined: no sub port; add_B=in_B always.

Test Plan:
- 128-bit add: start, Cin=0; words A={FFFFFFFF,FFFFFFFF,0,0}, B={1,0,0,0} (LSW first) -> out_S={0,0,1,0}; Cout per word 1,1,0,0; out_last on word 3; done pulse after its handshake.
- Carry-in and short op: start, Cin=1; single word A=7, B=8 with in_last=1 -> out_S=0x10, out_Cout=0, out_last=1, state returns to IDLE.
- Backpressure: hold out_ready=0 for 3 cycles after word 0 -> in_ready=0 and out_S stable; release -> back-to-back words accepted 1/cycle with correct carries.
- Forced last: NWORDS=4, send 4 words with in_last=0 -> word 3 has out_last=1; a fifth in_valid is not accepted (in_ready=0).
- Reset/start hygiene: assert rst after word 1 -> out_valid=0, word_cnt=0, IDLE; start during RUN ignored (carry_q unchanged).
- With ADDSEQ_SUBTRACT_EN: sub=1, A={0,1}, B={1,0} -> out_S={FFFFFFFF,0}, final out_Cout=1; A=0, B=1 single word -> FFFFFFFF, out_Cout=0.

Source files
------------

// File: rtl/multiword_add_sequencer.sv
// rtl/multiword_add_sequencer.sv - word-serial wide add/sub sequencer around an external 32-bit adder
// Optional subtract mode is enabled by defining ADDSEQ_SUBTRACT_EN.
module multiword_add_sequencer #(
    parameter int NWORDS = 4,
    parameter int CNT_W  = $clog2(NWORDS) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             Cin,
`ifdef ADDSEQ_SUBTRACT_EN
    input  logic             sub,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_A,
    input  logic [31:0]      in_B,
    input  logic             in_last,
    output logic [31:0]      add_A,
    output logic [31:0]      add_B,
    output logic             add_Cin,
    input  logic [31:0]      add_S,
    input  logic             add_Cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_S,
    output logic             out_last,
    output logic             out_Cout,
    output logic [CNT_W-1:0] word_cnt,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t state, state_nxt;
    logic   carry_q;
    logic   accept;
    logic   out_hs;
    logic   last_word;

    assign out_hs    = out_valid && out_ready;
    assign accept    = in_valid && in_ready;
    // Operation ends on in_last or when the word budget is exhausted.
    assign last_word = in_last || (word_cnt == CNT_W'(NWORDS - 1));

    assign add_A   = in_A;
    assign add_Cin = carry_q;

`ifdef ADDSEQ_SUBTRACT_EN
    logic sub_q;
    assign add_B = sub_q ? ~in_B : in_B;
`else
    assign add_B = in_B;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                in_ready = !out_valid || out_ready;
                if (in_valid && (!out_valid || out_ready) && last_word) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (out_hs) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            carry_q   <= 1'b0;
            word_cnt  <= '0;
            out_valid <= 1'b0;
            out_S     <= '0;
            out_last  <= 1'b0;
            out_Cout  <= 1'b0;
            done      <= 1'b0;
`ifdef ADDSEQ_SUBTRACT_EN
            sub_q     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (state == IDLE && start) begin
                word_cnt <= '0;
`ifdef ADDSEQ_SUBTRACT_EN
                sub_q    <= sub;
                carry_q  <= sub ? 1'b1 : Cin;
`else
                carry_q  <= Cin;
`endif
            end
            // A same-cycle accept reloads the register so out_valid never dips.
            if (accept) begin
                out_S     <= add_S;
                out_Cout  <= add_Cout;
                out_last  <= last_word;
                out_valid <= 1'b1;
                carry_q   <= add_Cout;
                word_cnt  <= word_cnt + CNT_W'(1);
            end else if (out_hs) begin
                out_valid <= 1'b0;
            end
            if (state == DRAIN && out_hs) begin
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// tb/tb_multiword_add_sequencer.sv - directed vector bench for multiword_add_sequencer
module tb_multiword_add_sequencer;

    localparam int NW = 4;
    localparam int CW = $clog2(NW) + 1;

    logic          clk;
    logic          rst;
    logic          start;
    logic          Cin;
    logic          sub;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_A;
    logic [31:0]   in_B;
    logic          in_last;
    logic [31:0]   add_A;
    logic [31:0]   add_B;
    logic          add_Cin;
    logic [31:0]   add_S;
    logic          add_Cout;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_S;
    logic          out_last;
    logic          out_Cout;
    logic [CW-1:0] word_cnt;
    logic          done;

    int checks = 0;
    int errors = 0;

    multiword_add_sequencer #(.NWORDS(NW), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .Cin       (Cin),
`ifdef ADDSEQ_SUBTRACT_EN
        .sub       (sub),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_A      (in_A),
        .in_B      (in_B),
        .in_last   (in_last),
        .add_A     (add_A),
        .add_B     (add_B),
        .add_Cin   (add_Cin),
        .add_S     (add_S),
        .add_Cout  (add_Cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_S     (out_S),
        .out_last  (out_last),
        .out_Cout  (out_Cout),
        .word_cnt  (word_cnt),
        .done      (done)
    );

    // Zero-latency 32-bit ripple adder sitting between add_* ports.
    assign {add_Cout, add_S} = {1'b0, add_A} + {1'b0, add_B} + {32'd0, add_Cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          new_op;
        bit          cin;
        logic [31:0] a;
        logic [31:0] b;
        bit          last;
        logic [31:0] es;
        bit          ec;
        bit          el;
    } vec_t;

    vec_t tv[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_start(input bit c);
        start = 1'b1;
        Cin   = c;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_word(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input bit last, input logic [31:0] es, input bit ec,
                             input bit el, input int ecnt);
        int n = 0;
        in_valid  = 1'b1;
        in_A      = a;
        in_B      = b;
        in_last   = last;
        out_ready = 1'b1;
        #1;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk({tag, ".accept"}, 64'(in_ready), 64'd1);
            in_valid = 1'b0;
        end else begin
            @(negedge clk);
            in_valid = 1'b0;
            chk({tag, ".out_valid"}, 64'(out_valid), 64'd1);
            chk({tag, ".out_S"},     64'(out_S),     64'(es));
            chk({tag, ".out_Cout"},  64'(out_Cout),  64'(ec));
            chk({tag, ".out_last"},  64'(out_last),  64'(el));
            chk({tag, ".word_cnt"},  64'(word_cnt),  64'(ecnt));
        end
    endtask

    task automatic finish_op(input string tag);
        int n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".done"},      64'(done),      64'd1);
        chk({tag, ".out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, ".in_ready"},  64'(in_ready),  64'd0);
        @(negedge clk);
        chk({tag, ".done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        tv[0]  = '{1, 0, 32'hFFFFFFFF, 32'h00000001, 0, 32'h00000000, 1, 0};
        tv[1]  = '{0, 0, 32'hFFFFFFFF, 32'h00000000, 0, 32'h00000000, 1, 0};
        tv[2]  = '{0, 0, 32'h00000000, 32'h00000000, 0, 32'h00000001, 0, 0};
        tv[3]  = '{0, 0, 32'h00000000, 32'h00000000, 1, 32'h00000000, 0, 1};
        tv[4]  = '{1, 1, 32'h00000007, 32'h00000008, 1, 32'h00000010, 0, 1};
        tv[5]  = '{1, 0, 32'h80000000, 32'h80000000, 0, 32'h00000000, 1, 0};
        tv[6]  = '{0, 0, 32'h00000001, 32'h00000001, 0, 32'h00000003, 0, 0};
        tv[7]  = '{0, 0, 32'hFFFFFFFF, 32'h00000000, 0, 32'hFFFFFFFF, 0, 0};
        tv[8]  = '{0, 0, 32'h12345678, 32'h11111111, 0, 32'h23456789, 0, 1};
        tv[9]  = '{1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'hFFFFFFFE, 1, 0};
        tv[10] = '{0, 0, 32'h00000000, 32'h00000000, 1, 32'h00000001, 0, 1};

        rst = 1'b1; start = 1'b0; Cin = 1'b0; sub = 1'b0;
        in_valid = 1'b0; in_A = '0; in_B = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.out_S",     64'(out_S),     64'd0);
        chk("rst.word_cnt",  64'(word_cnt),  64'd0);
        chk("rst.done",      64'(done),      64'd0);
        chk("rst.add_Cin",   64'(add_Cin),   64'd0);
        rst = 1'b0;

        // in_valid in IDLE must be ignored
        in_valid = 1'b1; in_A = 32'h5; in_B = 32'h5;
        repeat (2) @(negedge clk);
        chk("idle.in_ready",  64'(in_ready),  64'd0);
        chk("idle.out_valid", 64'(out_valid), 64'd0);
        chk("idle.word_cnt",  64'(word_cnt),  64'd0);
        in_valid = 1'b0;

        cnt = 0;
        for (int i = 0; i < 11; i++) begin
            if (tv[i].new_op) begin
                if (i > 0) finish_op($sformatf("v%0d.end", i));
                do_start(tv[i].cin);
                cnt = 0;
            end
            cnt++;
            send_word($sformatf("v%0d", i), tv[i].a, tv[i].b, tv[i].last,
                      tv[i].es, tv[i].ec, tv[i].el, cnt);
        end
        finish_op("v_final");

        // backpressure then back-to-back accepts
        do_start(1'b0);
        in_valid = 1'b1; in_A = 32'hFFFFFFFF; in_B = 32'h1; in_last = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        chk("bp.w0.S", 64'(out_S),    64'h0);
        chk("bp.w0.C", 64'(out_Cout), 64'd1);
        in_A = 32'h5; in_B = 32'h6;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp.hold.in_ready", 64'(in_ready),  64'd0);
            chk("bp.hold.out_S",    64'(out_S),     64'h0);
            chk("bp.hold.valid",    64'(out_valid), 64'd1);
            chk("bp.hold.cnt",      64'(word_cnt),  64'd1);
        end
        out_ready = 1'b1;
        #1 chk("bp.release.in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        chk("bp.w1.S",   64'(out_S),     64'hC);
        chk("bp.w1.C",   64'(out_Cout),  64'd0);
        chk("bp.w1.v",   64'(out_valid), 64'd1);
        chk("bp.w1.cnt", 64'(word_cnt),  64'd2);
        in_A = 32'h1; in_B = 32'h2; in_last = 1'b1;
        @(negedge clk);
        chk("bp.w2.S",    64'(out_S),    64'h3);
        chk("bp.w2.last", 64'(out_last), 64'd1);
        chk("bp.w2.cnt",  64'(word_cnt), 64'd3);
        in_valid = 1'b0; in_last = 1'b0;
        finish_op("bp.end");

        // forced last and a fifth word refused
        do_start(1'b0);
        send_word("f0", 32'h1, 32'h1, 0, 32'h2, 0, 0, 1);
        send_word("f1", 32'h2, 32'h2, 0, 32'h4, 0, 0, 2);
        send_word("f2", 32'h3, 32'h3, 0, 32'h6, 0, 0, 3);
        send_word("f3", 32'h4, 32'h4, 0, 32'h8, 0, 1, 4);
        out_ready = 1'b0; in_valid = 1'b1; in_A = 32'h9; in_B = 32'h9;
        #1 chk("f4.in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        chk("f4.cnt",   64'(word_cnt),  64'd4);
        chk("f4.S",     64'(out_S),     64'h8);
        chk("f4.valid", 64'(out_valid), 64'd1);
        finish_op("f.end");

        // start during RUN ignored, then mid-operation reset
        do_start(1'b1);
        send_word("r0", 32'h1, 32'h1, 0, 32'h3, 0, 0, 1);
        start = 1'b1; Cin = 1'b1;
        @(negedge clk);
        start = 1'b0; Cin = 1'b0;
        #1;
        chk("run_start.add_Cin",  64'(add_Cin),  64'd0);
        chk("run_start.word_cnt", 64'(word_cnt), 64'd1);
        chk("run_start.in_ready", 64'(in_ready), 64'd1);
        send_word("r1", 32'h2, 32'h2, 0, 32'h4, 0, 0, 2);
        rst = 1'b1;
        #1;
        chk("midrst.out_valid", 64'(out_valid), 64'd0);
        chk("midrst.word_cnt",  64'(word_cnt),  64'd0);
        chk("midrst.out_S",     64'(out_S),     64'd0);
        chk("midrst.in_ready",  64'(in_ready),  64'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b0;

        // start coinciding with DRAIN->IDLE is ignored
        do_start(1'b1);
        in_valid = 1'b1; in_A = 32'h7; in_B = 32'h8; in_last = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        chk("dr.S",        64'(out_S),    64'h10);
        chk("dr.last",     64'(out_last), 64'd1);
        chk("dr.in_ready", 64'(in_ready), 64'd0);
        start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("dr.done",  64'(done),      64'd1);
        chk("dr.valid", 64'(out_valid), 64'd0);
        in_valid = 1'b1;
        #1 chk("dr.start_ignored", 64'(in_ready), 64'd0);
        chk("dr.cnt_hold", 64'(word_cnt), 64'd1);
        in_valid = 1'b0;
        @(negedge clk);

`ifdef ADDSEQ_SUBTRACT_EN
        sub = 1'b1;
        do_start(1'b0);
        send_word("s0", 32'h0, 32'h1, 0, 32'hFFFFFFFF, 0, 0, 1);
        send_word("s1", 32'h1, 32'h0, 1, 32'h00000000, 1, 1, 2);
        finish_op("s.end");
        do_start(1'b0);
        send_word("s2", 32'h0, 32'h1, 1, 32'hFFFFFFFF, 0, 1, 1);
        finish_op("s2.end");
        sub = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
